digdug_custom_io_ctrl: RTL and testbench



---
 rtl/digdug_io_pkg.sv | 40 ++++
 rtl/digdug_credit_ctr.sv | 84 ++++++++
 rtl/digdug_custom_io_ctrl.sv | 143 ++++++++++++++
 tb/tb_digdug_custom_io_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/digdug_io_pkg.sv
// ============================================================================
// Module  : digdug_io_pkg
// Purpose : Shared constants and types for the Dig Dug custom I/O controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package digdug_io_pkg;

   localparam logic [7:0] CTRL_IDLE  = 8'h10;
   localparam logic [7:0] CMD_SWITCH = 8'h01;
   localparam logic [7:0] CMD_CREDIT = 8'h02;

   localparam int INP0_COIN1  = 0;
   localparam int INP0_COIN2  = 1;
   localparam int INP0_START1 = 2;
   localparam int INP0_START2 = 3;

   typedef enum logic {
      MODE_SWITCH = 1'b0,
      MODE_CREDIT = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      IDX_0 = 2'd0,
      IDX_1 = 2'd1,
      IDX_2 = 2'd2
   } idx_t;

   function automatic idx_t idx_next(input idx_t i);
      case (i)
         IDX_0:   return IDX_1;
         IDX_1:   return IDX_2;
         default: return IDX_0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/digdug_credit_ctr.sv
// ============================================================================
// Module  : digdug_credit_ctr
// Purpose : BCD credit counter sampled on VBLK rising edges (coins, starts).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module digdug_credit_ctr #(
   parameter logic [7:0] CREDIT_MAX = 8'h99
) (
   input  logic       CL,
   input  logic       RESET,
   input  logic       i_vblk,
   input  logic       i_enable,
   input  logic       i_coin1_n,
   input  logic       i_coin2_n,
   input  logic       i_start1_n,
   input  logic       i_start2_n,
   output logic [7:0] o_credits
);

   logic       r_vblk_d;
   logic [3:0] r_sw_prev;
   logic [7:0] r_credits;

   logic       w_vblk_rise;
   logic [3:0] w_sw;
   logic [3:0] w_fall;
   logic [7:0] w_after_add;
   logic [7:0] w_credits_next;

   function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
      if (v >= CREDIT_MAX)
         return CREDIT_MAX;
      if (v[3:0] >= 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   assign w_vblk_rise = i_vblk & ~r_vblk_d;
   assign w_sw        = {i_start2_n, i_start1_n, i_coin2_n, i_coin1_n};
   // Inputs are active-low, so a press is a 1->0 transition between samples.
   assign w_fall      = r_sw_prev & ~w_sw;

   always_comb begin
      w_after_add = r_credits;
      if (w_fall[0])
         w_after_add = bcd_inc_sat(w_after_add);
      if (w_fall[1])
         w_after_add = bcd_inc_sat(w_after_add);

      w_credits_next = w_after_add;
      if (w_fall[2] && (w_after_add >= 8'h01))
         w_credits_next = bcd_dec(w_after_add);
      else if (w_fall[3] && (w_after_add >= 8'h02))
         w_credits_next = bcd_dec(bcd_dec(w_after_add));
   end

   always_ff @(posedge CL or posedge RESET) begin
      if (RESET) begin
         r_vblk_d  <= 1'b0;
         r_sw_prev <= 4'hF;
         r_credits <= 8'h00;
      end else begin
         r_vblk_d <= i_vblk;
         if (w_vblk_rise) begin
            r_sw_prev <= w_sw;
            if (i_enable)
               r_credits <= w_credits_next;
         end
      end
   end

   assign o_credits = r_credits;

endmodule

`default_nettype wire

// File: rtl/digdug_custom_io_ctrl.sv
// ============================================================================
// Module  : digdug_custom_io_ctrl
// Purpose : 06xx-style bus/NMI controller with 51xx/53xx-style input reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module digdug_custom_io_ctrl
   import digdug_io_pkg::*;
#(
   parameter int         NMI_UNIT   = 256,
   parameter logic [7:0] CREDIT_MAX = 8'h99
) (
   input  logic       CL,
   input  logic       RESET,
   input  logic       VBLK,
   input  logic [7:0] INP0,
   input  logic [7:0] INP1,
   input  logic [7:0] DSW0,
   input  logic [7:0] DSW1,
   input  logic       CS,
   input  logic       WR,
   input  logic [4:0] AD,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   output logic       NMI
);

   localparam int CNT_W = $clog2(7 * NMI_UNIT + 1);

   logic [7:0]       r_ctrl;
   mode_t            r_mode;
   idx_t             r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic             r_nmi;
   logic             r_data_rd_d;
   logic             r_data_acc_d;

   logic             w_ctrl_wr;
   logic             w_data_wr;
   logic             w_data_rd;
   logic             w_data_acc;
   logic             w_rd_end;
   logic             w_acc_end;
   logic [2:0]       w_period;
   logic             w_nmi_en;
   logic [CNT_W-1:0] w_terminal;
   logic             w_wrap;
   logic [7:0]       w_credits;
   logic             w_unused;

   assign w_ctrl_wr  = CS &  WR &  AD[4];
   assign w_data_wr  = CS &  WR & ~AD[4];
   assign w_data_rd  = CS & ~WR & ~AD[4];
   assign w_data_acc = CS & ~AD[4];
   assign w_rd_end   = r_data_rd_d  & ~w_data_rd;
   assign w_acc_end  = r_data_acc_d & ~w_data_acc;
   assign w_unused   = ^AD[3:0];

   assign w_period   = r_ctrl[7:5];
   assign w_nmi_en   = (w_period != 3'd0);
   assign w_terminal = CNT_W'({29'd0, w_period} * 32'(NMI_UNIT) - 32'd1);
   assign w_wrap     = w_nmi_en && (r_cnt == w_terminal);

   always_ff @(posedge CL or posedge RESET) begin
      if (RESET) begin
         r_ctrl       <= CTRL_IDLE;
         r_mode       <= MODE_SWITCH;
         r_idx        <= IDX_0;
         r_cnt        <= '0;
         r_nmi        <= 1'b0;
         r_data_rd_d  <= 1'b0;
         r_data_acc_d <= 1'b0;
      end else begin
         r_data_rd_d  <= w_data_rd;
         r_data_acc_d <= w_data_acc;

         if (w_ctrl_wr) begin
            r_ctrl <= DI;
            r_cnt  <= '0;
            r_nmi  <= 1'b0;
            r_idx  <= IDX_0;
         end else begin
            if (w_nmi_en)
               r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;

            // An access end clears NMI even when the period wraps that cycle.
            if (w_acc_end)
               r_nmi <= 1'b0;
            else if (w_wrap)
               r_nmi <= 1'b1;

            if (w_rd_end)
               r_idx <= idx_next(r_idx);
         end

         if (w_data_wr && r_ctrl[0] && !r_ctrl[4]) begin
            if (DI == CMD_SWITCH)
               r_mode <= MODE_SWITCH;
            else if (DI == CMD_CREDIT)
               r_mode <= MODE_CREDIT;
         end
      end
   end

   digdug_credit_ctr #(
      .CREDIT_MAX (CREDIT_MAX)
   ) u_credit_ctr (
      .CL         (CL),
      .RESET      (RESET),
      .i_vblk     (VBLK),
      .i_enable   (r_mode == MODE_CREDIT),
      .i_coin1_n  (INP0[INP0_COIN1]),
      .i_coin2_n  (INP0[INP0_COIN2]),
      .i_start1_n (INP0[INP0_START1]),
      .i_start2_n (INP0[INP0_START2]),
      .o_credits  (w_credits)
   );

   always_comb begin
      DO = 8'hFF;
      if (AD[4]) begin
         DO = r_ctrl;
      end else if (r_ctrl[1:0] == 2'b01) begin
         case (r_idx)
            IDX_0:   DO = (r_mode == MODE_CREDIT) ? w_credits : ~INP0;
            IDX_1:   DO = {3'b000, ~INP1[4:0]};
            default: DO = {5'b00000, ~INP1[7:5]};
         endcase
      end else if (r_ctrl[1:0] == 2'b10) begin
         case (r_idx)
            IDX_0:   DO = DSW0;
            IDX_1:   DO = DSW1;
            default: DO = 8'h00;
         endcase
      end
   end

   assign NMI = r_nmi;

endmodule

`default_nettype wire

// File: tb/tb_digdug_custom_io_ctrl.sv
// ============================================================================
// Module  : tb_digdug_custom_io_ctrl
// Purpose : Directed self-checking bench for digdug_custom_io_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_digdug_custom_io_ctrl;

   logic       CL = 1'b0;
   logic       RESET;
   logic       VBLK;
   logic [7:0] INP0;
   logic [7:0] INP1;
   logic [7:0] DSW0;
   logic [7:0] DSW1;
   logic       CS;
   logic       WR;
   logic [4:0] AD;
   logic [7:0] DI;
   logic [7:0] DO;
   logic       NMI;

   int r_checks   = 0;
   int r_failures = 0;

   always #5 CL = ~CL;

   digdug_custom_io_ctrl #(
      .NMI_UNIT   (256),
      .CREDIT_MAX (8'h99)
   ) u_dut (
      .CL    (CL),
      .RESET (RESET),
      .VBLK  (VBLK),
      .INP0  (INP0),
      .INP1  (INP1),
      .DSW0  (DSW0),
      .DSW1  (DSW1),
      .CS    (CS),
      .WR    (WR),
      .AD    (AD),
      .DI    (DI),
      .DO    (DO),
      .NMI   (NMI)
   );

   task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      r_checks++;
      if (got !== exp) begin
         r_failures++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic ctrl_write(input logic [7:0] v);
      @(negedge CL);
      CS = 1'b1; WR = 1'b1; AD = 5'h10; DI = v;
      @(negedge CL);
      CS = 1'b0; WR = 1'b0; AD = 5'h00;
   endtask

   task automatic data_write(input logic [7:0] v);
      @(negedge CL);
      CS = 1'b1; WR = 1'b1; AD = 5'h00; DI = v;
      @(negedge CL);
      CS = 1'b0; WR = 1'b0;
   endtask

   task automatic ctrl_read(input string tag, input logic [7:0] exp);
      @(negedge CL);
      CS = 1'b1; WR = 1'b0; AD = 5'h10;
      #1 check8(tag, DO, exp);
      @(negedge CL);
      CS = 1'b0; AD = 5'h00;
   endtask

   task automatic data_read(input string tag, input logic [7:0] exp);
      @(negedge CL);
      CS = 1'b1; WR = 1'b0; AD = 5'h00;
      #1 check8(tag, DO, exp);
      @(negedge CL);
      CS = 1'b0;
   endtask

   task automatic read_credits(input string tag, input logic [7:0] exp);
      ctrl_write(8'h01);
      data_read(tag, exp);
   endtask

   task automatic vblk_pulse();
      @(negedge CL); VBLK = 1'b1;
      @(negedge CL);
      @(negedge CL); VBLK = 1'b0;
      @(negedge CL);
   endtask

   // mask bits: [0] coin1, [1] coin2, [2] start1, [3] start2
   task automatic press(input logic [7:0] mask);
      INP0 = 8'hFF ^ mask;
      vblk_pulse();
      INP0 = 8'hFF;
      vblk_pulse();
   endtask

   initial begin
      int hi;
      RESET = 1'b1; VBLK = 1'b0; INP0 = 8'hFF; INP1 = 8'hFF;
      DSW0 = 8'hA5; DSW1 = 8'h3C; CS = 1'b0; WR = 1'b0; AD = 5'h00; DI = 8'h00;
      repeat (3) @(negedge CL);
      RESET = 1'b0;

      ctrl_read("reset_ctrl", 8'h10);
      hi = 0;
      repeat (10000) begin
         @(negedge CL);
         if (NMI) hi++;
      end
      check8("nmi_idle", {7'd0, hi != 0}, 8'h00);

      // NMI period 1 step
      ctrl_write(8'h21);
      repeat (255) @(negedge CL);
      check8("nmi_pre", {7'd0, NMI}, 8'h00);
      @(negedge CL);
      check8("nmi_rise", {7'd0, NMI}, 8'h01);
      data_read("nmi_read", 8'h00);
      check8("nmi_hold", {7'd0, NMI}, 8'h01);
      @(negedge CL);
      check8("nmi_clr", {7'd0, NMI}, 8'h00);
      repeat (252) @(negedge CL);
      check8("nmi_pre2", {7'd0, NMI}, 8'h00);
      @(negedge CL);
      check8("nmi_rise2", {7'd0, NMI}, 8'h01);
      ctrl_write(8'h00);
      check8("nmi_ctrlclr", {7'd0, NMI}, 8'h00);

      // switch mode sequencing
      ctrl_write(8'h01);
      INP0 = 8'hFE; INP1 = 8'hA6;
      data_read("sw_idx0", 8'h01);
      data_read("sw_idx1", 8'h19);
      data_read("sw_idx2", 8'h02);
      data_read("sw_wrap", 8'h01);
      INP0 = 8'hFF; INP1 = 8'hFF;
      vblk_pulse();

      // credit mode
      data_write(8'h02);
      read_credits("cr_zero", 8'h00);
      repeat (12) press(8'h01);
      read_credits("cr_12", 8'h12);
      press(8'h02);
      read_credits("cr_coin2", 8'h13);
      press(8'h03);
      read_credits("cr_both", 8'h15);
      repeat (84) press(8'h01);
      read_credits("cr_99", 8'h99);
      press(8'h01);
      read_credits("cr_sat", 8'h99);
      press(8'h04);
      read_credits("cr_start1", 8'h98);
      ctrl_write(8'h01);
      data_write(8'h01);
      data_read("mode_sw", 8'h00);
      data_write(8'h02);
      read_credits("cr_keep", 8'h98);
      press(8'h08);
      read_credits("cr_start2", 8'h96);

      // credits return to zero on reset
      @(negedge CL); RESET = 1'b1;
      @(negedge CL); RESET = 1'b0;
      ctrl_write(8'h01);
      data_write(8'h02);
      data_read("cr_rst", 8'h00);
      press(8'h01);
      read_credits("cr_one", 8'h01);
      press(8'h08);
      read_credits("cr_s2_low", 8'h01);
      press(8'h04);
      read_credits("cr_s1", 8'h00);
      press(8'h05);
      read_credits("cr_same", 8'h00);

      // DIP switch chip and chip-select corner cases
      ctrl_write(8'h12);
      data_read("dsw0", 8'hA5);
      data_read("dsw1", 8'h3C);
      data_read("dsw2", 8'h00);
      data_read("dsw_wrap", 8'hA5);
      ctrl_write(8'h13);
      data_read("both_sel", 8'hFF);
      ctrl_write(8'h10);
      data_read("none_sel", 8'hFF);

      // reset in the middle of a read
      ctrl_write(8'h12);
      data_read("mid_dsw0", 8'hA5);
      @(negedge CL);
      CS = 1'b1; WR = 1'b0; AD = 5'h00;
      #1 check8("mid_dsw1", DO, 8'h3C);
      RESET = 1'b1;
      #1 check8("mid_rst_do", DO, 8'hFF);
      check8("mid_rst_nmi", {7'd0, NMI}, 8'h00);
      @(negedge CL); RESET = 1'b0;
      @(negedge CL); CS = 1'b0;
      ctrl_read("mid_ctrl", 8'h10);
      ctrl_write(8'h12);
      data_read("post_dsw0", 8'hA5);

      $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
      $finish;
   end

endmodule

`default_nettype wire
